div_unit: RTL and testbench

- Multicycle signed integer divider: the responder side of the control unit's start/done handshake for the DIV instruction.
- The control unit pulses start with operands taken from registers A and B, then waits on done.
- The divider runs restoring division, one quotient bit per cycle.
- It returns quotient to LO and remainder to HI, and flags divide-by-zero so the control unit can branch to its exception sequence.

---
 rtl/div_unit.sv | 114 +++++++++++
 tb/tb_div_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: multicycle signed restoring divider (MIPS DIV semantics).
// One quotient bit per clock; quotient returns on lo, remainder on hi.
// A zero divisor is answered at once with a done + div_zero pulse and
// leaves hi/lo untouched.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | waiting for start; answers divide-by-zero without leaving
//   RUN    | WIDTH restoring iterations on |dividend| / |divisor|
//   FINISH | apply signs, load hi/lo, pulse done, return to IDLE
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] dvsr;
  logic             sign_q;
  logic             sign_r;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;

  // Operand magnitudes (most-negative value maps to 2^(WIDTH-1) unsigned)
  // and the WIDTH+1-bit trial subtract; bit WIDTH is the borrow.
  always_comb begin
    abs_a  = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    abs_b  = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
    rem_sh = {rem, quot[WIDTH-1]};
    trial  = rem_sh - {1'b0, dvsr};
  end

  // Control FSM and datapath registers; all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rem      <= '0;
      quot     <= '0;
      dvsr     <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      count    <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              done     <= 1'b1;
              div_zero <= 1'b1;
            end else begin
              quot   <= abs_a;
              dvsr   <= abs_b;
              rem    <= '0;
              sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              sign_r <= dividend[WIDTH-1];
              count  <= '0;
              busy   <= 1'b1;
              state  <= RUN;
            end
          end
        end
        RUN: begin
          quot <= {quot[WIDTH-2:0], ~trial[WIDTH]};
          rem  <= trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
          count <= count + 1'b1;
          if (count == LAST_ITER) state <= FINISH;
        end
        FINISH: begin
          lo    <= sign_q ? (~quot + 1'b1) : quot;
          hi    <= sign_r ? (~rem + 1'b1) : rem;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vectors for div_unit with hand-computed results.
module tb_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  int n_chk  = 0;
  int n_pass = 0;
  int ov_cnt = 0;

  int   lat;
  int   bcnt;
  logic dz;
  int   extra_done;

  div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, act, exp);
  endtask

  // Present operands for one clock edge, then scramble them so a late
  // operand change would corrupt the result if the DUT did not latch.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 32'h5A5A1234;
    divisor  = 32'h0BADF00D;
  endtask

  // Wait (bounded) for done. inj > 0 pulses a stray start with 9/9 at that
  // cycle; chain re-launches na/nb in the done cycle.
  task automatic wait_done(input int inj, input bit chain,
                           input logic [31:0] na, input logic [31:0] nb,
                           output int l, output int bc, output logic z);
    l  = 0;
    bc = 0;
    z  = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (inj > 0 && i == inj) begin
        start = 1'b1; dividend = 32'd9; divisor = 32'd9;
      end else if (inj > 0 && i == inj + 1) begin
        start = 1'b0;
      end
      if (busy) bc++;
      if (busy && done) ov_cnt++;
      if (done) begin
        l = i;
        z = div_zero;
        if (chain) begin
          start = 1'b1; dividend = na; divisor = nb;
        end
        break;
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] elo, input logic [31:0] ehi);
    launch(a, b);
    wait_done(0, 1'b0, '0, '0, lat, bcnt, dz);
    check({tag, ".lat"}, lat, 34);
    check({tag, ".busy"}, bcnt, 33);
    check({tag, ".lo"}, lo, elo);
    check({tag, ".hi"}, hi, ehi);
    check({tag, ".dz"}, {31'b0, dz}, 32'd0);
    @(negedge clk);
    check({tag, ".done1"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst.lo", lo, 32'd0);
    check("rst.hi", hi, 32'd0);
    check("rst.busy", {31'b0, busy}, 32'd0);
    check("rst.done", {31'b0, done}, 32'd0);
    check("rst.dz", {31'b0, div_zero}, 32'd0);

    run_vec("p100_7", 32'd100, 32'd7, 32'd14, 32'd2);

    // divide by zero: immediate done+div_zero, hi/lo untouched, no busy
    launch(32'd55, 32'd0);
    wait_done(0, 1'b0, '0, '0, lat, bcnt, dz);
    check("dz.lat", lat, 1);
    check("dz.busy", bcnt, 0);
    check("dz.flag", {31'b0, dz}, 32'd1);
    check("dz.lo", lo, 32'd14);
    check("dz.hi", hi, 32'd2);
    @(negedge clk);
    check("dz.done1", {31'b0, done}, 32'd0);
    check("dz.flag1", {31'b0, div_zero}, 32'd0);
    check("dz.busy1", {31'b0, busy}, 32'd0);

    run_vec("m100_7", 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE);
    run_vec("p100_m7", 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2);
    run_vec("m100_m7", 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE);
    run_vec("m7_2", 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
    run_vec("minneg", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);
    run_vec("maxpos", 32'h7FFFFFFF, 32'd1, 32'h7FFFFFFF, 32'd0);
    run_vec("small_big", 32'd5, 32'h80000000, 32'd0, 32'd5);

    // stray start mid-operation is ignored
    launch(32'd10, 32'd3);
    wait_done(5, 1'b0, '0, '0, lat, bcnt, dz);
    check("ign.lat", lat, 34);
    check("ign.lo", lo, 32'd3);
    check("ign.hi", hi, 32'd1);
    @(negedge clk);
    check("ign.done1", {31'b0, done}, 32'd0);

    // change result first so the reset clearing is observable
    run_vec("p100_7b", 32'd100, 32'd7, 32'd14, 32'd2);

    // reset in flight
    launch(32'd10, 32'd3);
    repeat (9) @(negedge clk);
    check("mid.busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst2.lo", lo, 32'd0);
    check("rst2.hi", hi, 32'd0);
    check("rst2.busy", {31'b0, busy}, 32'd0);
    check("rst2.done", {31'b0, done}, 32'd0);
    check("rst2.dz", {31'b0, div_zero}, 32'd0);
    extra_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) extra_done++;
    end
    check("rst2.quiet", extra_done, 0);

    // back-to-back: second start in the done cycle of the first
    launch(32'd10, 32'd3);
    wait_done(0, 1'b1, 32'd20, 32'd6, lat, bcnt, dz);
    check("b2b1.lat", lat, 34);
    check("b2b1.lo", lo, 32'd3);
    check("b2b1.hi", hi, 32'd1);
    wait_done(0, 1'b0, '0, '0, lat, bcnt, dz);
    check("b2b2.lat", lat, 34);
    check("b2b2.busy", bcnt, 33);
    check("b2b2.lo", lo, 32'd3);
    check("b2b2.hi", hi, 32'd2);

    check("overlap", ov_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
